// File: rtl/seven_seg_scan_if.sv
// Display bus between the stopwatch time counter and the 7-segment scanner.
// Latency: n/a (signal bundle only).
// Backpressure: none; the scanner samples digits/freeze only at frame boundaries.
//
// Signals:
//   digits      packed 4-digit BCD, [3:0] = rightmost digit
//   freeze      1 = hold the current snapshot (lap display)
//   segments    active-low {g,f,e,d,c,b,a}
//   dp          active-low decimal point
//   anodes      active-low digit enables, bit i = digit i
//   frame_start one-cycle pulse after each snapshot boundary
interface seven_seg_scan_if;
    logic [15:0] digits;
    logic        freeze;
    logic [6:0]  segments;
    logic        dp;
    logic [3:0]  anodes;
    logic        frame_start;

    // Counter / display-source side.
    modport master (
        output digits,
        output freeze,
        input  segments,
        input  dp,
        input  anodes,
        input  frame_start
    );

    // Scanner side.
    modport slave (
        input  digits,
        input  freeze,
        output segments,
        output dp,
        output anodes,
        output frame_start
    );
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with per-frame snapshot.
// Latency: outputs follow the scan index one clock later; frame_start one clock after the wrap edge.
// Backpressure: none; digits/freeze are sampled only on the frame-boundary tick.
//
// Ports:
//   clock  rising-edge system clock
//   reset  asynchronous, active-high reset
//   bus    seven_seg_scan_if.slave: digits/freeze in; segments/dp/anodes/frame_start out
module seven_seg_scan #(
    parameter int REFRESH_DIV   = 100000,
    parameter int DP_POS        = 2,
    parameter int BLANK_LEADING = 1
) (
    input  logic             clock,
    input  logic             reset,
    seven_seg_scan_if.slave  bus
);

    localparam int             CW        = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]  PRESC_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [1:0]     DP_IDX    = 2'(DP_POS);
    localparam bit             BLANK_EN  = (BLANK_LEADING != 0);

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b0111111;  // invalid BCD shows a dash
        endcase
        return seg;
    endfunction

    logic [CW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic          fs_q, fs_d;
    logic [3:0]    anodes_q, anodes_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          tick;
    logic          wrap;
    logic [3:0]    cur_nib;
    logic [3:0]    nib_zero;
    logic [3:0]    lead_zero;
    logic          blank;

    always_comb begin
        tick     = (presc_q == PRESC_MAX);
        presc_d  = tick ? '0 : presc_q + CW'(1);
        idx_d    = tick ? idx_q + 2'd1 : idx_q;

        // Frame boundary: the slot-3 tick that takes the index back to 0.
        wrap     = tick && (idx_q == 2'd3);
        shadow_d = (wrap && !bus.freeze) ? bus.digits : shadow_q;
        fs_d     = wrap;

        for (int k = 0; k < 4; k++) begin
            nib_zero[k] = (shadow_q[4*k +: 4] == 4'd0);
        end

        // lead_zero[i] = nibbles i..3 are all zero.
        lead_zero[3] = nib_zero[3];
        lead_zero[2] = nib_zero[2] & lead_zero[3];
        lead_zero[1] = nib_zero[1] & lead_zero[2];
        lead_zero[0] = nib_zero[0] & lead_zero[1];

        cur_nib  = shadow_q[{idx_q, 2'b00} +: 4];
        blank    = BLANK_EN && (idx_q > DP_IDX) && lead_zero[idx_q];

        anodes_d = blank ? 4'b1111 : ~(4'b0001 << idx_q);
        seg_d    = blank ? 7'b1111111 : bcd_to_seg(cur_nib);
        dp_d     = !((idx_q == DP_IDX) && !blank);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q  <= '0;
            idx_q    <= 2'd0;
            shadow_q <= 16'h0000;
            fs_q     <= 1'b0;
            anodes_q <= 4'b1111;
            seg_q    <= 7'b1111111;
            dp_q     <= 1'b1;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            fs_q     <= fs_d;
            anodes_q <= anodes_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign bus.anodes      = anodes_q;
    assign bus.segments    = seg_q;
    assign bus.dp          = dp_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
module tb_seven_seg_scan;

    localparam int R     = 4;
    localparam int FRAME = 4 * R;
    localparam int DP    = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    seven_seg_scan_if bus();

    seven_seg_scan #(
        .REFRESH_DIV   (R),
        .DP_POS        (DP),
        .BLANK_LEADING (1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Reference model: n = rising edges since reset release. After edge n the
    // display shows slot ((n-1)/R)%4 of the value captured at the last frame
    // boundary strictly before edge n; boundaries fall on edges n%FRAME==0.
    int          n = 0;
    logic [15:0] sh = 16'h0;
    logic [15:0] disp_sh = 16'h0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            n       = 0;
            sh      = 16'h0;
            disp_sh = 16'h0;
        end else begin
            n       = n + 1;
            disp_sh = sh;
            if ((n % FRAME) == 0 && !bus.freeze) sh = bus.digits;
        end
    end

    int          slot;
    int          nib;
    bit          blank;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic        exp_fs;

    always @(negedge clock) begin
        if (reset || n == 0) begin
            check("rst_anodes",   32'(bus.anodes),      32'hF);
            check("rst_segments", 32'(bus.segments),    32'h7F);
            check("rst_dp",       32'(bus.dp),          32'h1);
            check("rst_fs",       32'(bus.frame_start), 32'h0);
        end else begin
            slot    = ((n - 1) / R) % 4;
            nib     = int'((disp_sh >> (4 * slot)) & 16'hF);
            blank   = (slot > DP) && ((disp_sh >> (4 * slot)) == 16'h0);
            exp_an  = blank ? 4'hF : (4'hF & ~(4'b0001 << slot));
            exp_seg = blank ? 7'h7F : seg_of(nib);
            exp_dp  = (!blank && slot == DP) ? 1'b0 : 1'b1;
            exp_fs  = ((n % FRAME) == 0);
            check("anodes",      32'(bus.anodes),      32'(exp_an));
            check("segments",    32'(bus.segments),    32'(exp_seg));
            check("dp",          32'(bus.dp),          32'(exp_dp));
            check("frame_start", 32'(bus.frame_start), 32'(exp_fs));
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clock);
    endtask

    function automatic logic [15:0] rand_digits();
        logic [15:0] v;
        int keep;
        v = 16'h0;
        keep = int'($urandom_range(0, 4));
        for (int i = 0; i < 4; i++) begin
            if (i < keep) begin
                // mostly valid BCD, occasionally an invalid nibble
                if ($urandom_range(0, 7) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
                else                           v[4*i +: 4] = 4'($urandom_range(0, 9));
            end
        end
        return v;
    endfunction

    int guard;

    initial begin
        bus.digits = 16'h0000;
        bus.freeze = 1'b0;
        reset      = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(2 * FRAME);

        bus.digits = 16'h1234;
        cyc(2 * FRAME + 5);
        bus.digits = 16'h5678;            // mid-frame change
        cyc(2 * FRAME);

        bus.digits = 16'h1234;
        cyc(FRAME + 3);
        bus.freeze = 1'b1;
        bus.digits = 16'h9999;
        cyc(3 * FRAME);
        bus.freeze = 1'b0;
        cyc(2 * FRAME);

        bus.digits = 16'h0056;
        cyc(2 * FRAME);
        bus.digits = 16'h12A4;
        cyc(2 * FRAME);

        for (int it = 0; it < 60; it++) begin
            bus.digits = rand_digits();
            bus.freeze = ($urandom_range(0, 3) == 0);
            cyc(int'($urandom_range(1, 30)));
        end
        bus.freeze = 1'b0;
        bus.digits = 16'h0307;
        cyc(2 * FRAME);

        // Asynchronous reset in the middle of slot 2.
        guard = 0;
        while (!(n > 0 && ((n - 1) / R) % 4 == 2) && guard < 64) begin
            @(negedge clock);
            guard++;
        end
        check("reach_slot2", 32'(guard < 64), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("async_anodes",   32'(bus.anodes),      32'hF);
        check("async_segments", 32'(bus.segments),    32'h7F);
        check("async_dp",       32'(bus.dp),          32'h1);
        check("async_fs",       32'(bus.frame_start), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        cyc(2 * FRAME);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
